sram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer in front of the single-port `sram` macro (23-bit word address, 256-bit data, `write_en`-controlled writes). It accepts one request at a time from either of two requesters over a valid/ready handshake. It drives the SRAM address, data and write-enable pins from registers, waits out the SRAM read latency and returns read data to the requester that issued the read. It sits between the cache/DMA-side clients and the `sram` instance.

---
 rtl/sram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and access sequencer for a
// single-port SRAM macro. One request is outstanding at a time. SRAM pins
// are driven from registers, and read data is returned to the port that
// issued the read once the SRAM read latency has elapsed.
module sram_arbiter #(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 256,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_in,
    output logic              sram_write_en,
    input  logic [DATA_W-1:0] sram_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_CNT = 3'(READ_LAT);

    state_t            state_q, state_d;
    logic              last_q, last_d;     // last granted port
    logic              gnt_q, gnt_d;       // port owning the current access
    logic              is_wr_q, is_wr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              resp0_q, resp0_d;
    logic              resp1_q, resp1_d;
    logic              gnt_sel;
    logic              hs;

    // Round-robin choice: the port that was not granted last wins a tie.
    // Ready is suppressed while reset is held so nothing is accepted.
    always_comb begin
        gnt_sel = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        hs      = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
    end

    assign req0_ready    = hs && !gnt_sel;
    assign req1_ready    = hs && gnt_sel;
    assign resp0_valid   = resp0_q;
    assign resp1_valid   = resp1_q;
    assign resp_rdata    = rdata_q;
    assign sram_address  = addr_q;
    assign sram_data_in  = wdata_q;
    assign sram_write_en = we_q;
    assign busy          = (state_q != IDLE);

    // Sequencer next-state: accept, drive pins, wait out latency, respond.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        is_wr_d = is_wr_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = 1'b0;
        resp0_d = 1'b0;
        resp1_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    last_d  = gnt_sel;
                    gnt_d   = gnt_sel;
                    is_wr_d = gnt_sel ? req1_we    : req0_we;
                    addr_d  = gnt_sel ? req1_addr  : req0_addr;
                    wdata_d = gnt_sel ? req1_wdata : req0_wdata;
                    we_d    = is_wr_d;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (is_wr_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = LAT_CNT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = sram_data_out;
                    resp0_d = !gnt_q;
                    resp1_d = gnt_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            is_wr_q <= 1'b0;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            is_wr_q <= is_wr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            resp0_q <= resp0_d;
            resp1_q <= resp1_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: randomized and directed traffic from two
// ports, a behavioural SRAM, and a scoreboard fed by an arbitration and
// timing reference model.
module tb_sram_arbiter #(
    parameter int LAT = 1
);

    typedef struct {
        int           port;
        logic [255:0] data;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         vld  [2];
    logic         we   [2];
    logic [22:0]  addr [2];
    logic [255:0] wd   [2];
    logic         rdy0, rdy1;
    logic         resp0_valid, resp1_valid;
    logic [255:0] resp_rdata;
    logic [22:0]  sram_address;
    logic [255:0] sram_data_in;
    logic         sram_write_en;
    logic [255:0] sram_data_out;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state
    logic [255:0] ref_mem [64];
    exp_t         q[$];
    int           free_at;
    logic         last_m;
    int           acc_cyc;
    logic [22:0]  acc_addr;
    logic         acc_we;
    logic [255:0] acc_data;
    logic         m_idle, m_g, er0, er1;
    int           hp;
    exp_t         e;

    // Behavioural SRAM
    logic [255:0] smem  [64];
    logic [255:0] rpipe [LAT];

    sram_arbiter #(.ADDR_W(23), .DATA_W(256), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0]), .req0_ready(rdy0), .req0_we(we[0]),
        .req0_addr(addr[0]), .req0_wdata(wd[0]),
        .req1_valid(vld[1]), .req1_ready(rdy1), .req1_we(we[1]),
        .req1_addr(addr[1]), .req1_wdata(wd[1]),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_rdata(resp_rdata),
        .sram_address(sram_address), .sram_data_in(sram_data_in),
        .sram_write_en(sram_write_en), .sram_data_out(sram_data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        rpipe[0] <= smem[sram_address[5:0]];
        if (sram_write_en) smem[sram_address[5:0]] = sram_data_in;
    end
    assign sram_data_out = rpipe[LAT-1];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int a);
        return {8{8'hA5, a[23:0]}};
    endfunction

    // Monitor: reference arbitration/timing model plus response scoreboard
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ctrl", {rdy0, rdy1, busy, sram_write_en, resp0_valid, resp1_valid}, '0);
            chk("rst_addr", sram_address, '0);
            chk("rst_din", sram_data_in, '0);
            chk("rst_rdata", resp_rdata, '0);
            q.delete();
            free_at = 0;
            last_m  = 1'b1;
            acc_cyc = -1;
        end else begin
            m_idle = (cyc >= free_at);
            m_g    = (vld[0] && vld[1]) ? !last_m : vld[1];
            er0    = m_idle && vld[0] && !m_g;
            er1    = m_idle && vld[1] && m_g;
            chk("ready", {rdy0, rdy1}, {er0, er1});
            chk("busy", busy, !m_idle);
            if (cyc == acc_cyc) begin
                chk("sram_addr", sram_address, acc_addr);
                chk("sram_we", sram_write_en, acc_we);
                if (acc_we) begin
                    chk("sram_din", sram_data_in, acc_data);
                    ref_mem[acc_addr[5:0]] = acc_data;
                end
            end else begin
                chk("sram_we_idle", sram_write_en, 1'b0);
            end
            if (resp0_valid || resp1_valid) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", {resp0_valid, resp1_valid}, 2'b00);
                end else begin
                    e = q.pop_front();
                    chk("resp_port", {resp0_valid, resp1_valid}, (e.port == 1) ? 2'b01 : 2'b10);
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_data", resp_rdata, e.data);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk("resp_missing", {resp0_valid, resp1_valid}, (e.port == 1) ? 2'b01 : 2'b10);
            end
            if (er0 || er1) begin
                hp       = er1 ? 1 : 0;
                last_m   = er1;
                acc_cyc  = cyc + 1;
                acc_addr = addr[hp];
                acc_we   = we[hp];
                acc_data = wd[hp];
                free_at  = cyc + (we[hp] ? 2 : 3 + LAT);
                if (!we[hp]) q.push_back('{port: hp, data: ref_mem[addr[hp][5:0]], due: cyc + 2 + LAT});
            end
        end
    end

    // Drive one request on port p; hold valid until accepted
    task automatic send(input int p, input logic w, input logic [22:0] a, input logic [255:0] d);
        logic got;
        got = 1'b0;
        vld[p] = 1'b1; we[p] = w; addr[p] = a; wd[p] = d;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? rdy0 : rdy1;
            @(posedge clk);
        end
        #1;
        chk("send_accepted", got, 1'b1);
        vld[p] = 1'b0;
    endtask

    task automatic rand_traffic(input int p);
        for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(p, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 63)), {8{$urandom}});
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            smem[i]    = '0;
        end
        for (int i = 0; i < LAT; i++) rpipe[i] = '0;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) begin
            vld[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wd[p] = '0;
        end
        free_at = 0; last_m = 1'b1; acc_cyc = -1;

        // Request pending while reset is held must not be accepted
        vld[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h5; wd[0] = {4{64'h1122334455667788}};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write then read on port 0
        send(0, 1'b1, 23'h5, {4{64'h1122334455667788}});
        send(0, 1'b0, 23'h5, '0);

        // Back-to-back writes from port 1
        for (int a = 0; a < 32; a++) send(1, 1'b1, 23'(a), pat(a));

        // Contention: both ports reading continuously
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 1'b0, 23'(2 * i), '0);
            end
            begin
                for (int i = 0; i < 4; i++) send(1, 1'b0, 23'(2 * i + 1), '0);
            end
        join

        // Read back all written locations
        for (int a = 0; a < 32; a++) send(0, 1'b0, 23'(a), '0);

        // Asynchronous reset during the ACCESS cycle of a write
        send(0, 1'b1, 23'h9, {8{32'hDEADBEEF}});
        #2;
        rst = 1'b1;
        #1;
        chk("async_we_drop", sram_write_en, 1'b0);
        chk("async_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 1'b0, 23'h9, '0);

        // Randomized mixed traffic on both ports
        fork
            rand_traffic(0);
            rand_traffic(1);
        join

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
